// File: rtl/bus_key_sequencer_if.sv
// Bus-side signal bundle for bus_key_sequencer: the bus master drives the access
// qualifiers and address, and the sequencer returns its registered status.
interface bus_key_sequencer_if #(
  parameter int ADDR_W = 4
);
  logic              sel_n;
  logic              page_hit;
  logic              bus_rw;
  logic              acc_stb;
  logic [ADDR_W-1:0] bus_addr;
  logic              unlocked;
  logic              data_oe;
  logic [2:0]        step;
  logic              seq_err;

  modport master (
    output sel_n, page_hit, bus_rw, acc_stb, bus_addr,
    input  unlocked, data_oe, step, seq_err
  );

  modport slave (
    input  sel_n, page_hit, bus_rw, acc_stb, bus_addr,
    output unlocked, data_oe, step, seq_err
  );
endinterface

// File: rtl/bus_key_sequencer.sv
// Knock-sequence gate: a fixed series of qualified reads opens a limited window
// of read grants, which closes on credit exhaustion, inactivity or a write.
module bus_key_sequencer #(
  parameter int                          ADDR_W       = 4,
  parameter int                          SEQ_LEN      = 4,
  parameter logic [ADDR_W*SEQ_LEN-1:0]   KEY          = 16'h2659,
  parameter int                          WINDOW       = 8,
  parameter int                          TIMEOUT      = 16,
  parameter bit                          RELOCK_ON_WR = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  bus_key_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_MATCH, S_OPEN} state_t;

  state_t      state_q;
  logic [2:0]  step_q;
  logic [7:0]  win_q;
  logic [7:0]  idle_q;
  logic        unlocked_q;
  logic        data_oe_q;
  logic        seq_err_q;

  logic              qual_rd;
  logic              qual_wr;
  logic              key_hit;
  logic              first_hit;
  logic              timed_out;
  logic [ADDR_W-1:0] key_arr [8];

  // Table is padded to 8 entries so the 3-bit step register indexes it directly.
  for (genvar gi = 0; gi < 8; gi++) begin : g_key
    if (gi < SEQ_LEN) begin : g_used
      assign key_arr[gi] = KEY[gi*ADDR_W +: ADDR_W];
    end else begin : g_pad
      assign key_arr[gi] = '0;
    end
  end

  assign qual_rd   = bus.acc_stb & ~bus.sel_n & bus.page_hit &  bus.bus_rw;
  assign qual_wr   = bus.acc_stb & ~bus.sel_n & bus.page_hit & ~bus.bus_rw;
  assign key_hit   = (bus.bus_addr == key_arr[step_q]);
  assign first_hit = (bus.bus_addr == key_arr[0]);
  assign timed_out = (idle_q >= 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      step_q     <= '0;
      win_q      <= '0;
      idle_q     <= '0;
      unlocked_q <= 1'b0;
      data_oe_q  <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      data_oe_q <= 1'b0;
      seq_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          idle_q <= '0;
          if (qual_rd && first_hit) begin
            state_q <= S_MATCH;
            step_q  <= 3'd1;
          end
        end

        S_MATCH: begin
          if (qual_rd) begin
            idle_q <= '0;
            if (key_hit) begin
              if (int'(step_q) + 1 == SEQ_LEN) begin
                state_q    <= S_OPEN;
                step_q     <= '0;
                unlocked_q <= 1'b1;
                win_q      <= 8'(WINDOW);
              end else begin
                step_q <= step_q + 3'd1;
              end
            end else begin
              seq_err_q <= 1'b1;
              // A wrong step that happens to be the first key restarts the sequence.
              if (first_hit) begin
                step_q <= 3'd1;
              end else begin
                state_q <= S_IDLE;
                step_q  <= '0;
              end
            end
          end else if (qual_wr) begin
            state_q   <= S_IDLE;
            step_q    <= '0;
            seq_err_q <= 1'b1;
            idle_q    <= '0;
          end else if (timed_out) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            idle_q  <= '0;
          end else begin
            idle_q <= idle_q + 8'd1;
          end
        end

        S_OPEN: begin
          if (qual_rd) begin
            idle_q    <= '0;
            data_oe_q <= 1'b1;
            if (win_q <= 8'd1) begin
              state_q    <= S_IDLE;
              unlocked_q <= 1'b0;
              win_q      <= '0;
            end else begin
              win_q <= win_q - 8'd1;
            end
          end else if (qual_wr) begin
            idle_q <= '0;
            if (RELOCK_ON_WR) begin
              state_q    <= S_IDLE;
              unlocked_q <= 1'b0;
              win_q      <= '0;
            end
          end else if (timed_out) begin
            state_q    <= S_IDLE;
            unlocked_q <= 1'b0;
            win_q      <= '0;
            idle_q     <= '0;
          end else begin
            idle_q <= idle_q + 8'd1;
          end
        end

        default: begin
          state_q    <= S_IDLE;
          step_q     <= '0;
          unlocked_q <= 1'b0;
          idle_q     <= '0;
        end
      endcase
    end
  end

  assign bus.unlocked = unlocked_q;
  assign bus.data_oe  = data_oe_q;
  assign bus.step     = step_q;
  assign bus.seq_err  = seq_err_q;

endmodule

// File: tb/tb_bus_key_sequencer.sv
// Directed bench for bus_key_sequencer; dut_a relocks on write, dut_b does not.
module tb_bus_key_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  always #5 clk = ~clk;

  bus_key_sequencer_if #(.ADDR_W(4)) bus_a ();
  bus_key_sequencer_if #(.ADDR_W(4)) bus_b ();

  bus_key_sequencer #(.RELOCK_ON_WR(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  bus_key_sequencer #(.RELOCK_ON_WR(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  task automatic check(input string tag, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  // One clock: drive at negedge, let the posedge sample, settle 1 time unit.
  task automatic cyc(input logic r, input logic stb, input logic rw,
                     input logic seln, input logic pg, input logic [3:0] addr);
    @(negedge clk);
    rst = r;
    bus_a.acc_stb = stb; bus_a.bus_rw = rw; bus_a.sel_n = seln;
    bus_a.page_hit = pg; bus_a.bus_addr = addr;
    bus_b.acc_stb = stb; bus_b.bus_rw = rw; bus_b.sel_n = seln;
    bus_b.page_hit = pg; bus_b.bus_addr = addr;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] a);   cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, a); endtask
  task automatic wr(input logic [3:0] a);   cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, a); endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
  endtask
  task automatic unlock();
    rd(4'd9); rd(4'd5); rd(4'd6); rd(4'd2);
  endtask

  task automatic outs(input string tag, input int unl, input int doe, input int stp, input int err);
    check({tag, ".unlocked"}, int'(bus_a.unlocked), unl);
    check({tag, ".data_oe"},  int'(bus_a.data_oe),  doe);
    check({tag, ".step"},     int'(bus_a.step),     stp);
    check({tag, ".seq_err"},  int'(bus_a.seq_err),  err);
  endtask

  initial begin
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    outs("reset", 0, 0, 0, 0);

    // Unqualified accesses are ignored.
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd9); check("sel_n_high", int'(bus_a.step), 0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd9); check("page_miss",  int'(bus_a.step), 0);
    wr(4'd9);                                check("idle_write", int'(bus_a.step), 0);

    // Full key.
    rd(4'd9); outs("key1", 0, 0, 1, 0);
    rd(4'd5); outs("key2", 0, 0, 2, 0);
    rd(4'd6); outs("key3", 0, 0, 3, 0);
    rd(4'd2); outs("key4", 1, 0, 0, 0);

    // Window of 8 grants, key values inside the window are plain data reads.
    for (int i = 0; i < 8; i++) begin
      rd(4'(9 - i % 2 * 4));
      check($sformatf("win%0d.data_oe", i), int'(bus_a.data_oe), 1);
      check($sformatf("win%0d.unlocked", i), int'(bus_a.unlocked), (i < 7) ? 1 : 0);
    end
    rd(4'd3); outs("win_over", 0, 0, 0, 0);

    // Mismatches.
    rd(4'd9); rd(4'd5); rd(4'd7); outs("mis_7", 0, 0, 0, 1);
    idle(1);                      outs("mis_7_after", 0, 0, 0, 0);
    rd(4'd9); rd(4'd5); rd(4'd9); outs("mis_9", 0, 0, 1, 1);
    rd(4'd5);                     outs("mis_9_cont", 0, 0, 2, 0);

    // MATCH timeout at exactly 16 idle clocks.
    idle(15); outs("tmo_m15", 0, 0, 2, 0);
    idle(1);  outs("tmo_m16", 0, 0, 0, 0);
    rd(4'd6); check("tmo_m_idle", int'(bus_a.step), 0);

    // Write in MATCH aborts.
    rd(4'd9); wr(4'd5); outs("match_wr", 0, 0, 0, 1);

    // OPEN timeout.
    unlock();
    idle(15); outs("tmo_o15", 1, 0, 0, 0);
    idle(1);  outs("tmo_o16", 0, 0, 0, 0);

    // Write in OPEN: relock vs ignore.
    unlock();
    wr(4'd1);
    check("relock_a", int'(bus_a.unlocked), 0);
    check("relock_b", int'(bus_b.unlocked), 1);
    check("relock_b_oe", int'(bus_b.data_oe), 0);
    rd(4'd1);
    check("relock_b_read_oe", int'(bus_b.data_oe), 1);
    check("relock_a_read_oe", int'(bus_a.data_oe), 0);

    // Reset mid-sequence, overriding a simultaneous final key read.
    rd(4'd9); rd(4'd5); rd(4'd6);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd2); outs("rst_mid", 0, 0, 0, 0);
    rd(4'd2); outs("rst_mid_need_full", 0, 0, 0, 0);

    // Reset inside the window.
    unlock(); rd(4'd0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0); outs("rst_win", 0, 0, 0, 0);
    check("rst_win_b", int'(bus_b.unlocked), 0);
    rd(4'd0); outs("rst_win_read", 0, 0, 0, 0);
    unlock(); outs("reunlock", 1, 0, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
